// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// CNT_W must match the CNT_W of the attached hazard_ctrl instance.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [4:0]       rs1E;
    logic [4:0]       rs2E;
    logic [4:0]       rdE;
    logic [4:0]       rdM;
    logic [4:0]       rdW;
    logic             regwriteE;
    logic             regwriteM;
    logic             regwriteW;
    logic             loadE;
    logic             pcSrcE;
    logic             memReqM;
    logic             memReadyM;
    logic [1:0]       forwardAE;
    logic [1:0]       forwardBE;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             flushW;
    logic             mem_err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output regwriteE, regwriteM, regwriteW, loadE, pcSrcE, memReqM, memReadyM,
        input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
        input  flushD, flushE, flushW, mem_err_o, stall_cnt_o
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  regwriteE, regwriteM, regwriteW, loadE, pcSrcE, memReqM, memReadyM,
        output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
        output flushD, flushE, flushW, mem_err_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/RAW stalls, branch flushes and data-memory wait/timeout.
// Optional macro HAZARD_FWD_EN enables E-stage forwarding; without it RAW hazards are resolved by stalling.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    hazard_ctrl_if.slave  hz
);
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_ERR     = 2'b10
    } state_e;

    state_e             state_r;
    state_e             state_nxt_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [WAIT_W-1:0]  wait_nxt_s;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic               mem_err_r;

    logic               mem_stall_s;
    logic               hazard_s;
    logic [1:0]         fwd_a_s;
    logic [1:0]         fwd_b_s;
    logic               stall_f_s;
    logic               stall_d_s;
    logic               stall_e_s;
    logic               stall_m_s;
    logic               flush_d_s;
    logic               flush_e_s;
    logic               flush_w_s;

    assign mem_stall_s = hz.memReqM & ~hz.memReadyM;

`ifdef HAZARD_FWD_EN
    // M-stage result wins over W because it is the younger write to the same register.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       rw_m,
        input logic [4:0] rd_m,
        input logic       rw_w,
        input logic [4:0] rd_w
    );
        if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign hazard_s = hz.loadE && (hz.rdE != 5'd0) &&
                      ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
`else
    function automatic logic raw_hit(
        input logic [4:0] rs,
        input logic       rw,
        input logic [4:0] rd
    );
        return (rs != 5'd0) && rw && (rd == rs);
    endfunction

    assign hazard_s = raw_hit(hz.rs1D, hz.regwriteE, hz.rdE) ||
                      raw_hit(hz.rs2D, hz.regwriteE, hz.rdE) ||
                      raw_hit(hz.rs1D, hz.regwriteM, hz.rdM) ||
                      raw_hit(hz.rs2D, hz.regwriteM, hz.rdM);

    logic unused_s;
    assign unused_s = ^{hz.rs1E, hz.rs2E, hz.rdW, hz.regwriteW, hz.loadE};
`endif

    // Memory wait state machine: next state and wait counter.
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        case (state_r)
            ST_RUN: begin
                wait_nxt_s = {WAIT_W{1'b0}};
                if (mem_stall_s) begin
                    state_nxt_s = ST_MEMWAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                if (hz.memReadyM) begin
                    state_nxt_s = ST_RUN;
                    wait_nxt_s  = {WAIT_W{1'b0}};
                end else if (wait_cnt_r >= TIMEOUT_C) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    wait_nxt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_RUN;
                wait_nxt_s  = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Stall/flush priority: ERR, memory stall, taken branch, data hazard; all forced low in reset.
    always_comb begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        stall_m_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        flush_w_s = 1'b0;
`ifdef HAZARD_FWD_EN
        fwd_a_s = fwd_sel(hz.rs1E, hz.regwriteM, hz.rdM, hz.regwriteW, hz.rdW);
        fwd_b_s = fwd_sel(hz.rs2E, hz.regwriteM, hz.rdM, hz.regwriteW, hz.rdW);
`else
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
`endif
        if (!reset_ni) begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end else if ((state_r == ST_ERR) || mem_stall_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
        end else if (hz.pcSrcE) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (hazard_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            stall_f_s = 1'b0;
        end
    end

    // State, wait counter, saturating stall counter and sticky timeout flag.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
            mem_err_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            mem_err_r  <= mem_err_r | (state_nxt_s == ST_ERR);
            if (stall_f_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign hz.forwardAE   = fwd_a_s;
    assign hz.forwardBE   = fwd_b_s;
    assign hz.stallF      = stall_f_s;
    assign hz.stallD      = stall_d_s;
    assign hz.stallE      = stall_e_s;
    assign hz.stallM      = stall_m_s;
    assign hz.flushD      = flush_d_s;
    assign hz.flushE      = flush_e_s;
    assign hz.flushW      = flush_w_s;
    assign hz.mem_err_o   = mem_err_r;
    assign hz.stall_cnt_o = stall_cnt_r;
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of consecutive memory-wait cycles before an error is declared.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall-cycle counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk_i  in  1  rising-edge clock; reset_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have the following decode-stage source registers: rs1D, rs2D  in  5 each.
REQ-005 SHALL have the following execute-stage source registers: rs1E, rs2E  in  5 each.
REQ-006 SHALL have the following destination registers: rdE, rdM, rdW  in  5 each, for the E, M and W stages.
REQ-007 SHALL have the following register-write enables: regwriteE, regwriteM, regwriteW  in  1 each.
REQ-008 SHALL have loadE  in  1, high when the instruction in E is a load (Res_Src==01).
REQ-009 SHALL have pcSrcE  in  1, high when a branch or jump is taken in E.
REQ-010 SHALL have memReqM  in  1 (load or store in M) and memReadyM  in  1 (data-memory acknowledge).
REQ-011 SHALL have forwardAE, forwardBE  out  2 each, driving the srcA/srcB muxes: 00 = register file, 01 = W result, 10 = M ALU result, 11 = never driven.
REQ-012 SHALL have stallF, stallD, stallE, stallM  out  1 each (pipeline register hold enables).
REQ-013 SHALL have flushD, flushE, flushW  out  1 each (pipeline register bubble enables).
REQ-014 SHALL have mem_err_o  out  1 (sticky memory-timeout flag) and stall_cnt_o  out  CNT_W (count of stalled cycles).

Function
REQ-015 SHALL implement a state machine with states RUN, MEMWAIT and ERR.
REQ-016 SHALL, in RUN, transition to MEMWAIT on memReqM=1 and memReadyM=0; it SHALL otherwise stay in RUN.
REQ-017 SHALL, in MEMWAIT, return to RUN on memReadyM=1; it SHALL go to ERR when the wait counter reaches MEM_TIMEOUT with memReadyM=0.
REQ-018 SHALL keep the wait counter cleared in RUN and increment it once per MEMWAIT cycle.
REQ-019 SHALL make ERR absorbing until reset, with mem_err_o=1, stallF/D/E/M=1 and flushW=1.
REQ-020 SHALL, when memory stalls (memReqM=1 and memReadyM=0, any non-ERR state), combinationally assert stallF/D/E/M=1 and flushW=1, and hold flushD=flushE=0.
REQ-021 SHALL set forwardAE=10 when regwriteM=1, rdM!=0 and rdM==rs1E; otherwise 01 when regwriteW=1, rdW!=0 and rdW==rs1E; otherwise 00 (M takes priority over W).
REQ-022 SHALL compute forwardBE with the same rules as REQ-021, using rs2E.
REQ-023 SHALL assert lwStall when loadE=1, rdE!=0, and rdE==rs1D or rdE==rs2D.
REQ-024 SHALL, on lwStall, set stallF=stallD=1 and flushE=1.
REQ-025 SHALL, on pcSrcE, set flushD=flushE=1 and override lwStall, so that stallF=stallD=0.
REQ-026 SHALL apply the priority order ERR > memory stall > pcSrcE > lwStall/RAW stall; a branch during a memory stall is deferred because E is held and pcSrcE re-presents.
REQ-027 SHALL increment stall_cnt_o on every rising edge with stallF=1, saturating at all-ones with no wrap.
REQ-028 SHALL resolve W-to-D hazards in the register file by write-through, so this block SHALL NOT stall for them.

Reset
REQ-029 SHALL, while reset_ni=0, force all outputs to 0, the state to RUN, the wait counter to 0, stall_cnt_o to 0 and mem_err_o to 0, asynchronously.
REQ-030 SHALL, on reset asserted mid-MEMWAIT or in ERR, abandon the wait immediately; the first cycle after release SHALL be in RUN.

Configuration
REQ-031 SHALL define forwarding behaviour by macro HAZARD_FWD_EN: when defined, forwarding follows REQ-021 and REQ-022.
REQ-032 SHALL, when HAZARD_FWD_EN is undefined, tie forwardAE/BE to 00 and replace lwStall with a RAW stall.
REQ-033 SHALL assert the RAW stall when rs1D or rs2D (nonzero) matches rdE with regwriteE=1 or rdM with regwriteM=1, with the same outputs and priority as lwStall.

Verification
REQ-034 SHALL cover forwarding: rdM=5, regwriteM=1, rdW=5, regwriteW=1, rs1E=5 -> forwardAE=10; with regwriteM=0 -> forwardAE=01; with rs1E=0 -> 00.
REQ-035 SHALL cover load-use: loadE=1, rdE=7, rs2D=7 -> one cycle of stallF=stallD=flushE=1; with pcSrcE=1 also -> stallF=0, flushD=flushE=1.
REQ-036 SHALL cover memory wait: memReqM=1, memReadyM=0 for 3 cycles, then 1 -> stallF-M=1 and flushW=1 for 3 cycles, RUN on the 4th, stall_cnt_o=3.
REQ-037 SHALL cover timeout: MEM_TIMEOUT=4, memReadyM held 0 -> ERR, mem_err_o=1 and sticky; reset_ni pulse -> all outputs 0, RUN.
REQ-038 SHALL cover saturation: CNT_W=4, 20 stall cycles -> stall_cnt_o=15.
REQ-039 SHALL cover HAZARD_FWD_EN undefined: regwriteM=1, rdM=3, rs1D=3 -> stallF=stallD=flushE=1, forwardAE=00.
